// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller.
//   - 4-bit TAP state encodings (IEEE 1149.1 conventional values)
//   - tap_state_e enum built on those encodings
//   - default instruction register length and opcodes
package jtag_pkg;

  localparam int IR_LEN_DEF = 5;

  localparam logic [4:0] IR_IDCODE_DEF = 5'h01;
  localparam logic [4:0] IR_DTMCS_DEF  = 5'h10;
  localparam logic [4:0] IR_DMI_DEF    = 5'h11;
  localparam logic [4:0] IR_BYPASS_DEF = 5'h1f;

  localparam logic [3:0] ST_TLR      = 4'hF;
  localparam logic [3:0] ST_RTI      = 4'hC;
  localparam logic [3:0] ST_SEL_DR   = 4'h7;
  localparam logic [3:0] ST_CAP_DR   = 4'h6;
  localparam logic [3:0] ST_SHIFT_DR = 4'h2;
  localparam logic [3:0] ST_EXIT1_DR = 4'h1;
  localparam logic [3:0] ST_PAUSE_DR = 4'h3;
  localparam logic [3:0] ST_EXIT2_DR = 4'h0;
  localparam logic [3:0] ST_UPD_DR   = 4'h5;
  localparam logic [3:0] ST_SEL_IR   = 4'h4;
  localparam logic [3:0] ST_CAP_IR   = 4'hE;
  localparam logic [3:0] ST_SHIFT_IR = 4'hA;
  localparam logic [3:0] ST_EXIT1_IR = 4'h9;
  localparam logic [3:0] ST_PAUSE_IR = 4'hB;
  localparam logic [3:0] ST_EXIT2_IR = 4'h8;
  localparam logic [3:0] ST_UPD_IR   = 4'hD;

  typedef enum logic [3:0] {
    TLR      = ST_TLR,
    RTI      = ST_RTI,
    SEL_DR   = ST_SEL_DR,
    CAP_DR   = ST_CAP_DR,
    SHIFT_DR = ST_SHIFT_DR,
    EXIT1_DR = ST_EXIT1_DR,
    PAUSE_DR = ST_PAUSE_DR,
    EXIT2_DR = ST_EXIT2_DR,
    UPD_DR   = ST_UPD_DR,
    SEL_IR   = ST_SEL_IR,
    CAP_IR   = ST_CAP_IR,
    SHIFT_IR = ST_SHIFT_IR,
    EXIT1_IR = ST_EXIT1_IR,
    PAUSE_IR = ST_PAUSE_IR,
    EXIT2_IR = ST_EXIT2_IR,
    UPD_IR   = ST_UPD_IR
  } tap_state_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with state decodes.
// Ports:
//   tck_i, trst_n_i  clock and asynchronous active-low reset
//   tms_i            test mode select, sampled on tck rise
//   enter_tlr_o      next state is TEST_LOGIC_RESET (used to reload IR)
//   capture_dr_o / shift_dr_o / update_dr_o   DR-side state decodes
//   capture_ir_o / shift_ir_o / update_ir_o   IR-side state decodes
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic tck_i,
  input  logic trst_n_i,
  input  logic tms_i,
  output logic enter_tlr_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_e state_reg, state_next;

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) state_reg <= TLR;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      TLR:      state_next = tms_i ? TLR      : RTI;
      RTI:      state_next = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_next = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next = tms_i ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_next = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_next = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_next = tms_i ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_next = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_next = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_next = tms_i ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_next = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_next = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_next = tms_i ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_next = tms_i ? SEL_DR   : RTI;
      default:  state_next = TLR;
    endcase
  end

  // The TLR reload keys off the next state so IR is already IDCODE
  // during the first cycle spent in TLR.
  assign enter_tlr_o  = (state_next == TLR);
  assign capture_dr_o = (state_reg == CAP_DR);
  assign shift_dr_o   = (state_reg == SHIFT_DR);
  assign update_dr_o  = (state_reg == UPD_DR);
  assign capture_ir_o = (state_reg == CAP_IR);
  assign shift_ir_o   = (state_reg == SHIFT_IR);
  assign update_ir_o  = (state_reg == UPD_IR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller, front end of the debug transport module.
// Owns the instruction register and the IDCODE/BYPASS data registers;
// DTMCS/DMI are decoded to selects plus DR strobes for the external DTM.
// Ports:
//   tck_i, trst_n_i   JTAG clock and asynchronous active-low reset
//   tms_i, tdi_i      sampled on tck rise
//   tdo_o, tdo_oe_o   serial out and its enable (high in SHIFT_IR/SHIFT_DR)
//   dtmcs_sel_o, dmi_sel_o                    IR decodes
//   capture_dr_o, shift_dr_o, update_dr_o    DR state strobes
//   ext_dr_tdo_i      LSB of the selected external DR
// Build option: JTAG_TAP_TDO_NEGEDGE_EN registers tdo_o/tdo_oe_o on the
// tck falling edge; otherwise they are combinational.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter logic [31:0]       TAP_IDCODE = 32'h0000_0001,
  parameter int                IR_LEN     = IR_LEN_DEF,
  parameter logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(IR_IDCODE_DEF),
  parameter logic [IR_LEN-1:0] IR_DTMCS   = IR_LEN'(IR_DTMCS_DEF),
  parameter logic [IR_LEN-1:0] IR_DMI     = IR_LEN'(IR_DMI_DEF),
  parameter logic [IR_LEN-1:0] IR_BYPASS  = IR_LEN'(IR_BYPASS_DEF)
) (
  input  logic tck_i,
  input  logic trst_n_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic dtmcs_sel_o,
  output logic dmi_sel_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  input  logic ext_dr_tdo_i
);

  logic enter_tlr, capture_ir, shift_ir, update_ir;
  logic [IR_LEN-1:0] ir_reg, ir_sr_reg;
  logic [31:0]       idcode_reg;
  logic              bypass_reg;
  logic              idcode_sel;
  logic              tdo_next, tdo_oe_next;

  jtag_tap_fsm u_fsm (
    .tck_i        (tck_i),
    .trst_n_i     (trst_n_i),
    .tms_i        (tms_i),
    .enter_tlr_o  (enter_tlr),
    .capture_dr_o (capture_dr_o),
    .shift_dr_o   (shift_dr_o),
    .update_dr_o  (update_dr_o),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir)
  );

  assign idcode_sel  = (ir_reg == IR_IDCODE);
  assign dtmcs_sel_o = (ir_reg == IR_DTMCS);
  assign dmi_sel_o   = (ir_reg == IR_DMI);

  // Instruction register and its shift stage
  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      ir_reg    <= IR_IDCODE;
      ir_sr_reg <= '0;
    end else begin
      if (capture_ir)    ir_sr_reg <= IR_LEN'(2'b01);
      else if (shift_ir) ir_sr_reg <= {tdi_i, ir_sr_reg[IR_LEN-1:1]};

      if (enter_tlr)      ir_reg <= IR_IDCODE;
      else if (update_ir) ir_reg <= ir_sr_reg;
    end
  end

  // IDCODE and BYPASS data registers
  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      idcode_reg <= '0;
      bypass_reg <= 1'b0;
    end else begin
      if (capture_dr_o && idcode_sel)    idcode_reg <= TAP_IDCODE;
      else if (shift_dr_o && idcode_sel) idcode_reg <= {tdi_i, idcode_reg[31:1]};

      if (capture_dr_o)    bypass_reg <= 1'b0;
      else if (shift_dr_o) bypass_reg <= tdi_i;
    end
  end

  // TDO source; anything that is not IDCODE/DTMCS/DMI falls back to BYPASS
  always_comb begin
    tdo_next    = 1'b0;
    tdo_oe_next = shift_ir | shift_dr_o;
    if (shift_ir) begin
      tdo_next = ir_sr_reg[0];
    end else if (shift_dr_o) begin
      if (idcode_sel)                    tdo_next = idcode_reg[0];
      else if (dtmcs_sel_o || dmi_sel_o) tdo_next = ext_dr_tdo_i;
      else                               tdo_next = bypass_reg;
    end
  end

`ifdef JTAG_TAP_TDO_NEGEDGE_EN
  logic tdo_reg, tdo_oe_reg;

  always_ff @(negedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else begin
      tdo_reg    <= tdo_next;
      tdo_oe_reg <= tdo_oe_next;
    end
  end

  assign tdo_o    = tdo_reg;
  assign tdo_oe_o = tdo_oe_reg;
`else
  assign tdo_o    = tdo_next;
  assign tdo_oe_o = tdo_oe_next;
`endif

endmodule
